fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Owns the architectural PC register and fetches one instruction per retire from instruction memory through a valid/ready request and valid response handshake.
- Sits directly downstream of the next-PC select mux: it consumes next_pc when the core retires the current instruction.
- Supplies instr, pc and pc_plus4 to decode/execute and to the next-PC mux.
- Handles multi-cycle memory latency, misaligned targets and fetch timeouts.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 255, maximum cycles spent in S_WAIT before a fetch-timeout error; 0 disables the watchdog.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- next_pc  in  32  target from the next-PC mux; sampled only when instr_ack=1.
- instr_ack  in  1  core retires the current instruction this cycle.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  fetched instruction word.
- instr  out  32  held instruction.
- instr_valid  out  1  instr is valid for the current pc.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, combinational, modulo 2^32.
- misalign_err  out  1  sticky flag: next_pc[1:0] != 0 at acknowledge.
- timeout_err  out  1  sticky flag: fetch watchdog expired.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0.
  - misalign_err=0, timeout_err=0, watchdog count=0, state=S_REQ.
  - imem_req_valid is 0 during any cycle in which rst=1.
- State S_REQ:
  - imem_req_valid=1, imem_addr=pc.
  - If imem_req_ready=1, go to S_WAIT.
  - imem_rsp_valid is ignored in this state.
- State S_WAIT:
  - imem_req_valid=0. The earliest legal response is the cycle after request accept.
  - If imem_rsp_valid=1: instr<=imem_rsp_data, instr_valid<=1, go to S_HOLD. Fetch latency is therefore at least 2 cycles from entering S_REQ.
  - Otherwise the watchdog counter increments. When it reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0): timeout_err<=1, go to S_ERR.
  - A response arriving on the expiry cycle wins over the timeout.
- State S_HOLD:
  - instr and instr_valid stay stable until instr_ack=1.
  - If instr_ack=1 and next_pc[1:0]==2'b00: pc<=next_pc, instr_valid<=0, watchdog count<=0, go to S_REQ.
  - If instr_ack=1 and next_pc[1:0]!=2'b00: misalign_err<=1, pc is unchanged, instr_valid<=0, go to S_ERR.
- State S_ERR:
  - Terminal state: imem_req_valid=0, instr_valid=0.
  - Error flags stay set; only rst leaves this state.
- instr_ack outside S_HOLD is ignored.
- next_pc == pc (self-loop) is legal and re-fetches the same address.
- pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000; no overflow flag.
- Reset mid-operation:
  - rst overrides every state, including an in-flight request.
  - The memory model must drop outstanding responses on the same rst, so no stale response can be captured.
- The unit never issues a second request while one is outstanding; at most one request is in flight.

Decomposition:
- Shared package rv32i_pkg holds:
  - XLEN=32.
  - NOP_INSTR=32'h0000_0013.
  - fetch_state_t enum {S_REQ, S_WAIT, S_HOLD, S_ERR}.
- Sub-module fetch_watchdog contains:
  - the counter of width $clog2(TIMEOUT_CYCLES+1);
  - clear/enable inputs and an expired output;
  - behaviour that ties expired to 0 when TIMEOUT_CYCLES=0.
- The FSM and PC register stay in fetch_unit.

Test Plan:
- Reset release with RESET_PC=0, memory returning 32'h00500093 one cycle after accept -> imem_addr=0; instr_valid=1 on cycle 3; instr=32'h00500093; pc_plus4=4.
- Ack with next_pc=4, then next_pc=32'h0000_0100 (branch) -> imem_addr sequence 0, 4, 0x100; instr_valid drops for exactly the fetch latency between acks.
- imem_req_ready held low 5 cycles, response delayed 3 cycles -> imem_req_valid and imem_addr stay stable while unaccepted; instr captured only on imem_rsp_valid.
- Ack with next_pc=32'h0000_0102 -> misalign_err=1 next cycle; pc unchanged; no further requests until rst.
- TIMEOUT_CYCLES=4 and no response -> timeout_err=1 after 4 cycles in S_WAIT. A response on exactly cycle 4 is captured and timeout_err stays 0.
- rst asserted in S_WAIT at pc=0x40 -> next cycle pc=RESET_PC, instr_valid=0, flags clear, new request to RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I widths, constants and fetch FSM state encoding
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } fetch_state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - fetch response watchdog; expires on the TIMEOUT_CYCLES-th idle wait cycle
module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired_o = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;

      always_comb begin
        count_d = count_q;
        if (clear_i) begin
          count_d = '0;
        end else if (enable_i) begin
          count_d = count_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      // Fires on the cycle the count would reach TIMEOUT_CYCLES, so a response then still wins.
      assign expired_o = enable_i && (count_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register and single-outstanding instruction fetch FSM
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] next_pc,
  input  logic            instr_ack,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_err,
  output logic            timeout_err
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            instr_valid_q;
  logic            misalign_q;
  logic            timeout_q;

  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  assign wd_clear  = (state_q == S_HOLD) && instr_ack;
  assign wd_enable = (state_q == S_WAIT) && !imem_rsp_valid;

  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req_ready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            instr_q       <= imem_rsp_data;
            instr_valid_q <= 1'b1;
            state_q       <= S_HOLD;
          end else if (wd_expired) begin
            timeout_q <= 1'b1;
            state_q   <= S_ERR;
          end
        end
        S_HOLD: begin
          if (instr_ack) begin
            instr_valid_q <= 1'b0;
            if (next_pc[1:0] == 2'b00) begin
              pc_q    <= next_pc;
              state_q <= S_REQ;
            end else begin
              misalign_q <= 1'b1;
              state_q    <= S_ERR;
            end
          end
        end
        S_ERR: begin
        end
      endcase
    end
  end

  // Gated by rst so a request never escapes during a reset cycle.
  assign imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem_addr      = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign misalign_err   = misalign_q;
  assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven and sequence checks for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I1  = 32'h0050_0093;
  localparam logic [31:0] I2  = 32'h00A0_0113;
  localparam logic [31:0] I3  = 32'h00F0_0193;
  localparam logic [31:0] I4  = 32'h0010_0213;
  localparam logic [31:0] I5  = 32'h0000_0513;
  localparam logic [31:0] I6  = 32'h0010_8093;
  localparam logic [31:0] TOP = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        instr_ack;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .next_pc       (next_pc),
    .instr_ack     (instr_ack),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .misalign_err  (misalign_err),
    .timeout_err   (timeout_err)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        ack;
    logic [31:0] npc;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_mis;
    logic        e_to;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rdata,
                     input logic ack, input logic [31:0] npc, input logic e_rqv,
                     input logic [31:0] e_addr, input logic e_iv, input logic [31:0] e_instr,
                     input logic [31:0] e_pc, input logic e_mis, input logic e_to);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.ack = ack; v.npc = npc;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_instr = e_instr;
    v.e_pc = e_pc; v.e_mis = e_mis; v.e_to = e_to;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0; instr_ack = 1'b0; next_pc = 32'h0;
  endtask

  // One reactive fetch: stall ready, delay response, then retire with npc.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                       input int rdy_dly, input int rsp_dly, input logic [31:0] npc);
    int  n;
    bit  extra;
    n = 0;
    while (!imem_req_valid && n < 20) begin
      step();
      n++;
    end
    chk("seq_req_seen", imem_req_valid, 1'b1);
    chk("seq_addr", imem_addr, exp_addr);
    for (int k = 0; k < rdy_dly; k++) begin
      step();
      chk("seq_req_held", imem_req_valid, 1'b1);
      chk("seq_addr_held", imem_addr, exp_addr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    extra = 1'b0;
    for (int k = 0; k < rsp_dly; k++) begin
      if (imem_req_valid || instr_valid) extra = 1'b1;
      step();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    chk("seq_single_outstanding", {31'b0, extra}, 32'h0);
    chk("seq_iv", instr_valid, 1'b1);
    chk("seq_instr", instr, data);
    chk("seq_pc", pc, exp_addr);
    instr_ack = 1'b1;
    next_pc   = npc;
    step();
    instr_ack = 1'b0;
    chk("seq_pc_next", pc, npc);
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;

    //   rst rdy rv rdata        ack npc           rqv addr          iv instr pc            mis to
    add(1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 0, 1, I1,           0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, I1,  32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h4,        0, 32'h0,        1, I1,  32'h0,        0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0, I1,  32'h4,        0, 0);
    add(0, 0, 1, I2,           0, 32'h0,        0, 32'h4,        0, I1,  32'h4,        0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h100,      0, 32'h4,        1, I2,  32'h4,        0, 0);
    // request held unaccepted for five cycles; stray response and ack ignored
    add(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, I2,  32'h100,      0, 0);
    add(0, 0, 1, 32'hDEADBEEF, 0, 32'h0,        1, 32'h100,      0, I2,  32'h100,      0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h200,      1, 32'h100,      0, I2,  32'h100,      0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, I2,  32'h100,      0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, I2,  32'h100,      0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h100,      0, I2,  32'h100,      0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      0, I2,  32'h100,      0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      0, I2,  32'h100,      0, 0);
    add(0, 0, 1, I3,           0, 32'h0,        0, 32'h100,      0, I2,  32'h100,      0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      1, I3,  32'h100,      0, 0);
    // misaligned target
    add(0, 0, 0, 32'h0,        1, 32'h102,      0, 32'h100,      1, I3,  32'h100,      0, 0);
    add(0, 1, 1, 32'hCAFEF00D, 1, 32'h200,      0, 32'h100,      0, I3,  32'h100,      1, 0);
    add(0, 1, 1, 32'hCAFEF00D, 1, 32'h200,      0, 32'h100,      0, I3,  32'h100,      1, 0);
    add(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      0, I3,  32'h100,      1, 0);
    // timeout with no response
    add(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 1, 1, 32'h0000ABCD, 0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 1);
    add(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 1);
    // response exactly on the expiry cycle wins
    add(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 0, 1, I4,           0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h40,       0, 32'h0,        1, I4,  32'h0,        0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h40,       0, I4,  32'h40,       0, 0);
    // reset in S_WAIT at 0x40 with a response on the same edge
    add(1, 0, 1, 32'hBAD0BAD0, 0, 32'h0,        0, 32'h40,       0, I4,  32'h40,       0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, NOP, 32'h0,        0, 0);
    add(0, 0, 1, I5,           0, 32'h0,        0, 32'h0,        0, NOP, 32'h0,        0, 0);
    // PC wrap and self-loop at the top of the address space
    add(0, 0, 0, 32'h0,        1, TOP,          0, 32'h0,        1, I5,  32'h0,        0, 0);
    add(0, 1, 0, 32'h0,        0, 32'h0,        1, TOP,          0, I5,  TOP,          0, 0);
    add(0, 0, 1, I6,           0, 32'h0,        0, TOP,          0, I5,  TOP,          0, 0);
    add(0, 0, 0, 32'h0,        1, TOP,          0, TOP,          1, I6,  TOP,          0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h0,        1, TOP,          0, I6,  TOP,          0, 0);

    repeat (2) step();

    for (int i = 0; i < vecs.size(); i++) begin
      rst            = vecs[i].rst;
      imem_req_ready = vecs[i].rdy;
      imem_rsp_valid = vecs[i].rv;
      imem_rsp_data  = vecs[i].rdata;
      instr_ack      = vecs[i].ack;
      next_pc        = vecs[i].npc;
      #4;
      chk($sformatf("r%0d_req_valid", i), imem_req_valid, vecs[i].e_rqv);
      chk($sformatf("r%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("r%0d_instr_valid", i), instr_valid, vecs[i].e_iv);
      chk($sformatf("r%0d_instr", i), instr, vecs[i].e_instr);
      chk($sformatf("r%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("r%0d_pc_plus4", i), pc_plus4, vecs[i].e_pc + 32'd4);
      chk($sformatf("r%0d_misalign", i), misalign_err, vecs[i].e_mis);
      chk($sformatf("r%0d_timeout", i), timeout_err, vecs[i].e_to);
      @(posedge clk);
      #1;
    end

    drive_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    fetch(32'h0, I1, 2, 3, 32'h8);
    fetch(32'h8, I2, 0, 0, 32'h8);
    fetch(32'h8, I3, 1, 1, 32'h0);
    chk("seq_wrap_plus4", pc_plus4, 32'h4);
    chk("seq_no_err", {30'b0, misalign_err, timeout_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
